// File: rtl/calc_pkg.sv
// Command and response codes for the N-port calculator core.
// The port FSM state type is shared between the core and its benches.
package calc_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP2,
        ST_WAIT,
        ST_BUSY
    } port_state_e;

endpackage

// File: rtl/calc_alu.sv
// Shared ALU. The result is formed combinationally at issue and then delayed through
// ALU_LAT-1 register stages; the core's output register supplies the final stage.
module calc_alu
    import calc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ALU_LAT = 2,
    parameter int TAG_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    input  logic [3:0]        in_cmd_i,
    input  logic [DATA_W-1:0] in_op1_i,
    input  logic [DATA_W-1:0] in_op2_i,
    output logic              out_valid_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic [1:0]        out_resp_o,
    output logic [DATA_W-1:0] out_data_o
);
    localparam int SH_W = $clog2(DATA_W);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
    } slot_t;

    slot_t           res;
    slot_t           out_slot;
    logic [DATA_W:0] sum;
    logic [SH_W-1:0] shamt;

    always_comb begin
        sum   = {1'b0, in_op1_i} + {1'b0, in_op2_i};
        shamt = in_op2_i[SH_W-1:0];
        res   = '0;
        if (in_valid_i) begin
            res.valid = 1'b1;
            res.tag   = in_tag_i;
            res.resp  = RESP_OK;
            case (in_cmd_i)
                CMD_ADD: begin
                    if (sum[DATA_W]) res.resp = RESP_ERR;
                    else             res.data = sum[DATA_W-1:0];
                end
                CMD_SUB: begin
                    if (in_op2_i > in_op1_i) res.resp = RESP_ERR;
                    else                     res.data = in_op1_i - in_op2_i;
                end
                CMD_SHL: res.data = in_op1_i << shamt;
                CMD_SHR: res.data = in_op1_i >> shamt;
                default: res.resp = RESP_ERR;
            endcase
        end
    end

    if (ALU_LAT == 1) begin : g_comb
        assign out_slot = res;
    end else begin : g_pipe
        slot_t pipe_q [ALU_LAT-1];

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                for (int i = 0; i < ALU_LAT-1; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= res;
                for (int i = 1; i < ALU_LAT-1; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign out_slot = pipe_q[ALU_LAT-2];
    end

    assign out_valid_o = out_slot.valid;
    assign out_tag_o   = out_slot.tag;
    assign out_resp_o  = out_slot.resp;
    assign out_data_o  = out_slot.data;

endmodule

// File: rtl/calcn_core.sv
// N-port calculator core: per-port request FSMs, round-robin arbiter into one shared ALU,
// and per-port one-cycle response registers selected by the returning tag.
//   state   | meaning
//   IDLE    | waiting for a nonzero cmd; captures cmd and op1
//   OP2     | captures op2 from the data lane; cmd ignored
//   WAIT    | requesting the ALU
//   BUSY    | issued; leaves when this port's output register loads
module calcn_core
    import calc_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W = 32,
    parameter int ALU_LAT = 2
) (
    input  logic                        c_clk,
    input  logic                        reset_n,
    input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
    input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
    output logic [2*NUM_PORTS-1:0]      out_resp,
    output logic [DATA_W*NUM_PORTS-1:0] out_data
);
    localparam int TAG_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]        wait_vec;
    logic [4*NUM_PORTS-1:0]      cmd_flat;
    logic [DATA_W*NUM_PORTS-1:0] op1_flat;
    logic [DATA_W*NUM_PORTS-1:0] op2_flat;

    logic             gnt_valid;
    logic [TAG_W-1:0] gnt_idx;
    logic [TAG_W-1:0] ptr_q, ptr_d;

    logic              alu_valid;
    logic [TAG_W-1:0]  alu_tag;
    logic [1:0]        alu_resp;
    logic [DATA_W-1:0] alu_data;

    // Search begins at ptr_q and wraps; ptr_q then moves just past the winner.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!gnt_valid && wait_vec[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = TAG_W'(idx);
            end
        end
        ptr_d = ptr_q;
        if (gnt_valid) ptr_d = (int'(gnt_idx) == NUM_PORTS-1) ? '0 : gnt_idx + TAG_W'(1);
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    calc_alu #(
        .DATA_W (DATA_W),
        .ALU_LAT(ALU_LAT),
        .TAG_W  (TAG_W)
    ) u_alu (
        .clk_i      (c_clk),
        .rst_n_i    (reset_n),
        .in_valid_i (gnt_valid),
        .in_tag_i   (gnt_idx),
        .in_cmd_i   (cmd_flat[4*gnt_idx +: 4]),
        .in_op1_i   (op1_flat[DATA_W*gnt_idx +: DATA_W]),
        .in_op2_i   (op2_flat[DATA_W*gnt_idx +: DATA_W]),
        .out_valid_o(alu_valid),
        .out_tag_o  (alu_tag),
        .out_resp_o (alu_resp),
        .out_data_o (alu_data)
    );

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        port_state_e       state_q, state_d;
        logic [3:0]        cmd_q, cmd_d;
        logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
        logic [1:0]        oresp_q, oresp_d;
        logic [DATA_W-1:0] odata_q, odata_d;
        logic              hit;

        assign hit = alu_valid && (alu_tag == TAG_W'(p));

        always_comb begin
            state_d = state_q;
            cmd_d   = cmd_q;
            op1_d   = op1_q;
            op2_d   = op2_q;
            oresp_d = hit ? alu_resp : RESP_NONE;
            odata_d = hit ? alu_data : '0;
            case (state_q)
                ST_IDLE: begin
                    if (req_cmd_in[4*p +: 4] != CMD_NOP) begin
                        cmd_d   = req_cmd_in[4*p +: 4];
                        op1_d   = req_data_in[DATA_W*p +: DATA_W];
                        state_d = ST_OP2;
                    end
                end
                ST_OP2: begin
                    op2_d   = req_data_in[DATA_W*p +: DATA_W];
                    state_d = ST_WAIT;
                end
                ST_WAIT: if (gnt_valid && gnt_idx == TAG_W'(p)) state_d = ST_BUSY;
                ST_BUSY: if (hit) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge c_clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_IDLE;
                cmd_q   <= CMD_NOP;
                op1_q   <= '0;
                op2_q   <= '0;
                oresp_q <= RESP_NONE;
                odata_q <= '0;
            end else begin
                state_q <= state_d;
                cmd_q   <= cmd_d;
                op1_q   <= op1_d;
                op2_q   <= op2_d;
                oresp_q <= oresp_d;
                odata_q <= odata_d;
            end
        end

        assign wait_vec[p]                     = (state_q == ST_WAIT);
        assign cmd_flat[4*p +: 4]              = cmd_q;
        assign op1_flat[DATA_W*p +: DATA_W]    = op1_q;
        assign op2_flat[DATA_W*p +: DATA_W]    = op2_q;
        assign out_resp[2*p +: 2]              = oresp_q;
        assign out_data[DATA_W*p +: DATA_W]    = odata_q;
    end

endmodule

// File: tb/tb_calcn_core.sv
// Bench for calcn_core: directed and random requests checked against an arithmetic
// model plus a round-robin service-order model; a second small build covers DATA_W=8.
module tb_calcn_core;
    import calc_pkg::*;

    logic         c_clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [15:0]  req_cmd_in = '0;
    logic [127:0] req_data_in = '0;
    logic [7:0]   out_resp;
    logic [127:0] out_data;

    logic [7:0]   cmd8 = '0;
    logic [15:0]  data8 = '0;
    logic [3:0]   resp8;
    logic [15:0]  odata8;

    int vectors = 0;
    int miscompares = 0;
    int rr_ptr = 0;

    logic [3:0]  b_cmd [4];
    logic [31:0] b_op1 [4];
    logic [31:0] b_op2 [4];

    calcn_core #(.NUM_PORTS(4), .DATA_W(32), .ALU_LAT(2)) dut (
        .c_clk      (c_clk),
        .reset_n    (reset_n),
        .req_cmd_in (req_cmd_in),
        .req_data_in(req_data_in),
        .out_resp   (out_resp),
        .out_data   (out_data)
    );

    calcn_core #(.NUM_PORTS(2), .DATA_W(8), .ALU_LAT(1)) dut8 (
        .c_clk      (c_clk),
        .reset_n    (reset_n),
        .req_cmd_in (cmd8),
        .req_data_in(data8),
        .out_resp   (resp8),
        .out_data   (odata8)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge c_clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic [7:0] er, input logic [127:0] ed);
        vectors++;
        assert (out_resp === er) else begin
            miscompares++;
            $error("FAIL %s out_resp got %h expected %h", tag, out_resp, er);
        end
        vectors++;
        assert (out_data === ed) else begin
            miscompares++;
            $error("FAIL %s out_data got %h expected %h", tag, out_data, ed);
        end
    endtask

    task automatic check8(input string tag, input logic [3:0] er, input logic [15:0] ed);
        vectors++;
        assert (resp8 === er) else begin
            miscompares++;
            $error("FAIL %s resp8 got %h expected %h", tag, resp8, er);
        end
        vectors++;
        assert (odata8 === ed) else begin
            miscompares++;
            $error("FAIL %s odata8 got %h expected %h", tag, odata8, ed);
        end
    endtask

    function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic [1:0] r, output logic [31:0] d);
        logic [63:0] s;
        r = 2'd1;
        d = '0;
        case (c)
            4'd1: begin
                s = 64'(a) + 64'(b);
                if (s > 64'h0000_0000_FFFF_FFFF) r = 2'd2;
                else d = s[31:0];
            end
            4'd2: begin
                if (b > a) r = 2'd2;
                else d = a - b;
            end
            4'd5: d = a << (b % 32);
            4'd6: d = a >> (b % 32);
            default: r = 2'd2;
        endcase
    endfunction

    // Masked ports all issue at the same E0; service follows the round-robin order.
    task automatic run_batch(input logic [3:0] mask, input string tag);
        int          ord[$];
        int          n;
        int          k;
        logic [1:0]  r;
        logic [31:0] d;
        logic [7:0]  er;
        logic [127:0] ed;
        for (int p = 0; p < 4; p++) if (mask[p]) begin
            req_cmd_in[4*p +: 4]   = b_cmd[p];
            req_data_in[32*p +: 32] = b_op1[p];
        end
        tick;
        for (int p = 0; p < 4; p++) begin
            req_cmd_in[4*p +: 4] = 4'd0;
            if (mask[p]) req_data_in[32*p +: 32] = b_op2[p];
        end
        tick;
        req_data_in = '0;
        for (int i = 0; i < 4; i++) if (mask[(rr_ptr + i) % 4]) ord.push_back((rr_ptr + i) % 4);
        n = ord.size();
        rr_ptr = (ord[n-1] + 1) % 4;
        for (int cyc = 2; cyc <= 3 + n; cyc++) begin
            tick;
            er = '0;
            ed = '0;
            if (cyc >= 3 && cyc - 3 < n) begin
                k = ord[cyc-3];
                ref_alu(b_cmd[k], b_op1[k], b_op2[k], r, d);
                er[2*k +: 2]  = r;
                ed[32*k +: 32] = d;
            end
            check_bus($sformatf("%s_e%0d", tag, cyc), er, ed);
        end
    endtask

    task automatic set_req(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        b_cmd[p] = c;
        b_op1[p] = a;
        b_op2[p] = b;
    endtask

    initial begin
        logic [3:0] mask;
        int         sel;
        logic [127:0] ed;

        #1 reset_n = 1'b0;
        tick;
        tick;
        check_bus("reset_hold", '0, '0);
        check8("reset_hold8", '0, '0);
        reset_n = 1'b1;
        tick;

        set_req(0, CMD_SUB, 32'h1FFF_FFFF, 32'h0000_0007);
        run_batch(4'b0001, "sub_p0");

        set_req(1, CMD_ADD, 32'hFFFF_FFFF, 32'h1);
        run_batch(4'b0010, "add_ovf_p1");
        set_req(1, CMD_SHL, 32'h1, 32'd31);
        run_batch(4'b0010, "shl31_p1");
        set_req(1, CMD_SHR, 32'h4, 32'd33);
        run_batch(4'b0010, "shr33_p1");

        set_req(2, CMD_SUB, 32'h0008_0000, 32'h0010_0000);
        run_batch(4'b0100, "sub_unf_p2");
        set_req(3, CMD_SUB, 32'h0000_8000, 32'h0);
        run_batch(4'b1000, "sub_zero_p3");

        for (int p = 0; p < 4; p++) set_req(p, CMD_ADD, 32'h1, 32'h1);
        run_batch(4'b1111, "all4");
        run_batch(4'b1001, "p0p3");

        set_req(0, 4'd3, 32'h1234, 32'h5678);
        run_batch(4'b0001, "invalid_p0");

        // cmd held on port0 while it waits and is busy must not start a second request
        req_cmd_in[3:0] = CMD_ADD; req_data_in[31:0] = 32'd5;
        tick;
        req_cmd_in[3:0] = 4'd0; req_data_in[31:0] = 32'd6;
        tick;
        req_cmd_in[3:0] = CMD_ADD; req_data_in[31:0] = 32'h77;
        tick;
        check_bus("busy_e2", '0, '0);
        tick;
        req_cmd_in[3:0] = 4'd0; req_data_in[31:0] = '0;
        check_bus("busy_e3", 8'h01, 128'd11);
        for (int i = 4; i <= 6; i++) begin
            tick;
            check_bus($sformatf("busy_e%0d", i), '0, '0);
        end
        rr_ptr = 1;

        // port2 issues its next command during its response cycle
        req_cmd_in[11:8] = CMD_ADD; req_data_in[95:64] = 32'd2;
        tick;
        req_cmd_in[11:8] = 4'd0; req_data_in[95:64] = 32'd3;
        tick;
        req_data_in[95:64] = '0;
        tick;
        tick;
        ed = '0; ed[95:64] = 32'd5;
        check_bus("b2b_first", 8'h10, ed);
        req_cmd_in[11:8] = CMD_SUB; req_data_in[95:64] = 32'd10;
        tick;
        check_bus("b2b_gap", '0, '0);
        req_cmd_in[11:8] = 4'd0; req_data_in[95:64] = 32'd4;
        tick;
        req_data_in[95:64] = '0;
        tick;
        check_bus("b2b_wait", '0, '0);
        tick;
        ed = '0; ed[95:64] = 32'd6;
        check_bus("b2b_second", 8'h10, ed);
        tick;
        check_bus("b2b_after", '0, '0);
        rr_ptr = 3;

        // reset while a response is showing clears it immediately
        req_cmd_in[3:0] = CMD_ADD; req_data_in[31:0] = 32'd7;
        tick;
        req_cmd_in[3:0] = 4'd0; req_data_in[31:0] = 32'd8;
        tick;
        req_data_in[31:0] = '0;
        tick;
        tick;
        check_bus("pre_reset_resp", 8'h01, 128'd15);
        reset_n = 1'b0;
        #1;
        check_bus("reset_async", '0, '0);
        tick;
        reset_n = 1'b1;
        rr_ptr = 0;
        tick;

        // reset while port1 is busy: its request is never answered
        req_cmd_in[7:4] = CMD_ADD; req_data_in[63:32] = 32'd1;
        tick;
        req_cmd_in[7:4] = 4'd0; req_data_in[63:32] = 32'd2;
        tick;
        req_data_in[63:32] = '0;
        tick;
        reset_n = 1'b0;
        #1;
        check_bus("reset_busy", '0, '0);
        tick;
        tick;
        reset_n = 1'b1;
        rr_ptr = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            check_bus($sformatf("post_reset_%0d", i), '0, '0);
        end

        for (int it = 0; it < 30; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int p = 0; p < 4; p++) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: b_cmd[p] = CMD_ADD;
                    1: b_cmd[p] = CMD_SUB;
                    2: b_cmd[p] = CMD_SHL;
                    3: b_cmd[p] = CMD_SHR;
                    4: b_cmd[p] = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'($urandom_range(7, 15));
                    default: b_cmd[p] = CMD_ADD;
                endcase
                b_op1[p] = $urandom;
                b_op2[p] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
                if ($urandom_range(0, 5) == 0) b_op1[p] = 32'hFFFF_FFFF;
            end
            run_batch(mask, $sformatf("rand%0d", it));
        end

        // DATA_W=8, ALU_LAT=1 build: both ports contend, port0 first
        cmd8 = {CMD_ADD, CMD_ADD}; data8 = 16'hF0F0;
        tick;
        cmd8 = '0; data8 = 16'h100F;
        tick;
        data8 = '0;
        check8("w8_e1", '0, '0);
        tick;
        check8("w8_p0_add", 4'b0001, 16'h00FF);
        tick;
        check8("w8_p1_ovf", 4'b1000, 16'h0000);
        tick;
        check8("w8_idle", '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
